// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshakes, iterative shifts and a persistent {N,Z,C,V} flag register.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode 0111); otherwise 0111 is illegal.
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err,
  output logic             busy
);

  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q, result_hi_q, sh_q;
  logic [3:0]       flags_q;
  logic             err_q, dir_q;
  logic [CW-1:0]    cnt_q;

  logic is_add, is_sub, is_and, is_or, is_xor, is_shl, is_shr, is_mul, legal;
  logic accept, go_busy;
  logic [SW-1:0]    amt;
  logic [WIDTH:0]   cin_w, sum_w, diff_w;
  logic [WIDTH-1:0] imm_res, load_val;
  logic [CW-1:0]    load_cnt;
  logic             imm_c, imm_v;
  logic [WIDTH-1:0] step_lo, step_hi;
  logic [3:0]       step_fl;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign err       = err_q;
  assign amt       = b[SW-1:0];

  always_comb begin
    is_add = 1'b0;
    is_sub = 1'b0;
    is_and = 1'b0;
    is_or  = 1'b0;
    is_xor = 1'b0;
    is_shl = 1'b0;
    is_shr = 1'b0;
    is_mul = 1'b0;
    case (op)
      4'b0100, 4'b1100: is_add = 1'b1;
      4'b0101, 4'b1101: is_sub = 1'b1;
      4'b0110, 4'b1110: is_and = 1'b1;
      4'b1000, 4'b1001: is_or  = 1'b1;
      4'b1010, 4'b1011: is_xor = 1'b1;
      4'b0010:          is_shl = 1'b1;
      4'b0011:          is_shr = 1'b1;
`ifdef ALU_SEQ_MUL_EN
      4'b0111:          is_mul = 1'b1;
`endif
      default: ;
    endcase
    legal = is_add | is_sub | is_and | is_or | is_xor | is_shl | is_shr | is_mul;
  end

  // op[3] distinguishes ADC/SBB from ADD/SUB; carry/borrow-in is the stored C flag.
  assign cin_w  = {{WIDTH{1'b0}}, op[3] & flags_q[1]};
  assign sum_w  = {1'b0, a} + {1'b0, b} + cin_w;
  assign diff_w = {1'b0, a} - {1'b0, b} - cin_w;

  always_comb begin
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    if (is_add) begin
      imm_res = sum_w[WIDTH-1:0];
      imm_c   = sum_w[WIDTH];
      imm_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
    end else if (is_sub) begin
      imm_res = diff_w[WIDTH-1:0];
      imm_c   = diff_w[WIDTH];
      imm_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
    end else if (is_and) begin
      imm_res = a & b;
    end else if (is_or) begin
      imm_res = a | b;
    end else if (is_xor) begin
      imm_res = a ^ b;
    end else if (is_shl || is_shr) begin
      imm_res = a;
    end
  end

  always_comb begin
    go_busy  = (is_shl || is_shr) && (amt != '0);
    load_val = a;
    load_cnt = {1'b0, amt};
    if (is_mul) begin
      go_busy  = 1'b1;
      load_val = b;
      load_cnt = CW'(WIDTH);
    end
  end

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   mc_q, hi_q;
  logic               mul_q;
  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] prod_next;

  // Shift-add: sh_q holds the multiplier and fills with product low bits from the top.
  assign madd      = {1'b0, hi_q} + (sh_q[0] ? {1'b0, mc_q} : '0);
  assign prod_next = {madd, sh_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_q  <= '0;
      hi_q  <= '0;
      mul_q <= 1'b0;
    end else if (state_q == BUSY) begin
      hi_q <= step_hi;
    end else if (accept) begin
      mc_q  <= a;
      hi_q  <= '0;
      mul_q <= is_mul;
    end
  end
`endif

  always_comb begin
    step_lo = dir_q ? (sh_q >> 1) : (sh_q << 1);
    step_hi = '0;
    step_fl = {step_lo[WIDTH-1], step_lo == '0, dir_q ? sh_q[0] : sh_q[WIDTH-1], 1'b0};
`ifdef ALU_SEQ_MUL_EN
    if (mul_q) begin
      step_lo = prod_next[WIDTH-1:0];
      step_hi = prod_next[2*WIDTH-1:WIDTH];
      step_fl = {prod_next[WIDTH-1], prod_next == '0, step_hi != '0, step_hi != '0};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
    end else if (state_q == BUSY) begin
      sh_q  <= step_lo;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_q     <= DONE;
        result_q    <= step_lo;
        result_hi_q <= step_hi;
        flags_q     <= step_fl;
        err_q       <= 1'b0;
      end
    end else if (accept) begin
      if (go_busy) begin
        state_q <= BUSY;
        sh_q    <= load_val;
        cnt_q   <= load_cnt;
        dir_q   <= is_shr;
      end else begin
        state_q     <= DONE;
        result_q    <= imm_res;
        result_hi_q <= '0;
        err_q       <= ~legal;
        if (legal) flags_q <= {imm_res[WIDTH-1], imm_res == '0, imm_c, imm_v};
      end
    end else if ((state_q == DONE) && out_ready) begin
      state_q <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push expected responses, an independent monitor pops and compares.
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, err, busy;
  logic [W-1:0] result, result_hi;
  logic [3:0]   flags;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .flags(flags), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  typedef struct {
    int           id;
    logic [3:0]   op;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   fl;
    logic         er;
    int           lat;
    int           bsy;
    int           acc;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor
  bit mon_seen = 1'b0;
  int mon_bcnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        mon_seen = 1'b0;
        mon_bcnt = 0;
      end else begin
        if (busy) mon_bcnt++;
        if (out_valid && !mon_seen) begin
          mon_seen = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: out_valid=1 with no transaction outstanding");
          end else begin
            chk("latency", cyc - exp_q[0].acc + 1, exp_q[0].lat);
            chk("busy_cycles", mon_bcnt, exp_q[0].bsy);
          end
        end
        if (out_valid && out_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("result_hi", result_hi, e.hi);
          chk("flags", flags, e.fl);
          chk("err", err, e.er);
          $display("txn %0d op=%b: result=%02h result_hi=%02h flags=%b err=%b", e.id, e.op, result,
                   result_hi, flags, err);
          mon_seen = 1'b0;
          mon_bcnt = 0;
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] er, input logic [W-1:0] eh, input logic [3:0] ef,
                       input logic ee, input int lat, input int bsy, output int waits);
    exp_t e;
    op = o;
    a = aa;
    b = bb;
    in_valid = 1'b1;
    waits = 0;
    #1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", waits);
      in_valid = 1'b0;
      @(negedge clk);
      return;
    end
    e.id = txn_id;
    txn_id++;
    e.op = o;
    e.res = er;
    e.hi = eh;
    e.fl = ef;
    e.er = ee;
    e.lat = lat;
    e.bsy = bsy;
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_result_hi", result_hi, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b1;

    //     op       a      b      res    hi     {NZCV}   err lat busy
    issue(4'b0100, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1001, 0, 1, 0, w);
    issue(4'b0100, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0110, 0, 1, 0, w);
    issue(4'b1100, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000, 0, 1, 0, w);
    issue(4'b0101, 8'h03, 8'h05, 8'hFE, 8'h00, 4'b1010, 0, 1, 0, w);
    issue(4'b0001, 8'h12, 8'h34, 8'h00, 8'h00, 4'b1010, 1, 1, 0, w);
    issue(4'b1101, 8'h05, 8'h03, 8'h01, 8'h00, 4'b0000, 0, 1, 0, w);
    issue(4'b0011, 8'h81, 8'h01, 8'h40, 8'h00, 4'b0010, 0, 2, 1, w);
    issue(4'b0010, 8'h81, 8'h03, 8'h08, 8'h00, 4'b0000, 0, 4, 3, w);
    issue(4'b0010, 8'hA5, 8'h00, 8'hA5, 8'h00, 4'b1000, 0, 1, 0, w);
    issue(4'b0110, 8'h3C, 8'h0F, 8'h0C, 8'h00, 4'b0000, 0, 1, 0, w);
    issue(4'b1001, 8'h50, 8'h05, 8'h55, 8'h00, 4'b0000, 0, 1, 0, w);
    issue(4'b1011, 8'h80, 8'h00, 8'h80, 8'h00, 4'b1000, 0, 1, 0, w);
`ifdef ALU_SEQ_MUL_EN
    issue(4'b0111, 8'h10, 8'h20, 8'h00, 8'h02, 4'b0011, 0, 9, 8, w);
    issue(4'b0111, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0011, 0, 9, 8, w);
`else
    issue(4'b0111, 8'h10, 8'h20, 8'h00, 8'h00, 4'b1000, 1, 1, 0, w);
    issue(4'b0111, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'b1000, 1, 1, 0, w);
`endif
    drain();

    // Back-pressure: result must hold while out_ready is low, then retire and accept on one edge.
    out_ready = 1'b0;
    issue(4'b1010, 8'hF0, 8'hFF, 8'h0F, 8'h00, 4'b0000, 0, 1, 0, w);
    repeat (5) begin
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 8'h0F);
      chk("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue(4'b1110, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 0, 1, 0, w);
    chk("same_edge_accept_waits", w, 0);
    drain();

    // Asynchronous reset four cycles into a multiply.
    out_ready = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    issue(4'b0111, 8'h10, 8'h20, 8'h00, 8'h02, 4'b0011, 0, 9, 8, w);
`else
    issue(4'b0111, 8'h10, 8'h20, 8'h00, 8'h00, 4'b0000, 1, 1, 0, w);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_result_hi", result_hi, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b1;
    issue(4'b0000, 8'h5A, 8'hA5, 8'h00, 8'h00, 4'b0000, 1, 1, 0, w);
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the datapath's combinational 8-bit ALU.
- Keeps the existing 4-bit opcode encoding and adds carry-chained add/subtract, iterative shifts, an optional iterative multiplier and a persistent flag register.
- Operands enter and results leave through valid/ready handshakes, so the block can sit between the decode stage and register-file writeback with back-pressure.

Parameters:
- WIDTH, 8, operand/result width; power of 2, at least 4.
- SW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation.
- op  in  4  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts, the amount is b[SW-1:0].
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  low result.
- result_hi  out  WIDTH  product high half for MUL; 0 for all other ops.
- flags  out  4  {N,Z,C,V}, registered.
- err  out  1  illegal opcode; valid with out_valid.
- busy  out  1  high while in the BUSY state.

Behaviour:
- Opcodes:
  - 0100 ADD: a+b.
  - 1100 ADC: a+b+C.
  - 0101 SUB: a-b.
  - 1101 SBB: a-b-C.
  - 0110/1110 AND.
  - 1000/1001 OR.
  - 1010/1011 XOR.
  - 0010 SHL and 0011 SHR: logical shifts, zero fill.
  - 0111 MUL: unsigned.
  - All other opcodes are illegal.
- Acceptance: an op is accepted on a rising edge with in_valid && in_ready. Operands and op are captured, so inputs may change afterwards.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back acceptance from DONE is allowed.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept of logic/add/sub, a shift with amount 0, or an illegal op: go to DONE next edge. Latency 1.
  - IDLE, accept of a shift with amount k>0: go to BUSY. Shift one bit per cycle; DONE after k cycles. Latency k+1.
  - IDLE, accept of MUL: go to BUSY. Shift-add runs for WIDTH cycles, then DONE. Latency WIDTH+1.
  - DONE: out_valid=1. result, result_hi, flags and err are held stable until out_ready.
  - DONE with out_ready: go to IDLE, or take a new op per the rules above.
- Flags: updated when a legal op enters DONE; illegal ops leave flags unchanged.
  - N = result[WIDTH-1].
  - Z = (full result, including result_hi, == 0).
  - ADD/ADC: C = carry out; V = signed overflow.
  - SUB/SBB: C = 1 on borrow (unsigned a < b + borrow-in); V = signed overflow.
  - Logic ops: C=0, V=0.
  - Shifts: C = last bit shifted out (0 if amount is 0); V=0.
  - MUL: C = V = (result_hi != 0).
- Illegal op: result=0, result_hi=0, err=1 for that transaction. err=0 for legal ops.
- Widths: all arithmetic is WIDTH+1 bits internally, and the result is truncated to WIDTH. The MUL product is 2*WIDTH bits.
- Reset (asynchronous, any state including mid-BUSY):
  - State goes to IDLE and any in-flight op is discarded.
  - out_valid=0, result=0, result_hi=0, flags=0, err=0, busy=0.
  - in_ready=1 on the first cycle after reset deasserts.
- Simultaneous events: in DONE, out_ready and in_valid in the same cycle retire the old result and accept the new op on the same edge. No bubble is allowed and no result may be lost.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL (0111) is implemented as above.
- Undefined: the multiplier datapath is omitted. 0111 is an illegal opcode (err=1, latency 1, flags unchanged) and result_hi is tied to 0.

Test Plan:
- Reset, then ADD a=0x7F b=0x01 with out_ready=1 -> out_valid exactly 1 cycle after accept; result=0x80, flags N=1 Z=0 C=0 V=1, err=0.
- ADD 0xFF+0x01 -> result=0x00, Z=1, C=1. Then ADC 0x00+0x00 -> result=0x01, C=0. Then SUB 0x03-0x05 -> result=0xFE, N=1, C=1.
- SHR a=0x81 b=0x01 -> out_valid 2 cycles after accept, result=0x40, C=1. SHL a=0x81 b=0x03 -> out_valid 4 cycles after accept, result=0x08, C=0.
- With ALU_SEQ_MUL_EN, MUL 0x10×0x20 -> busy=1 for 8 cycles, out_valid at cycle 9, result=0x00, result_hi=0x02, C=1, V=1, Z=0. Without the macro -> err=1 at cycle 1, flags unchanged.
- Hold out_ready=0 for 5 cycles after XOR 0xF0^0xFF -> result=0x0F held stable, in_ready=0. Then out_ready=1 with a new in_valid -> new op accepted on the same edge.
- Assert rst mid-MUL (cycle 4) -> immediately state IDLE, out_valid=0, all outputs 0. Illegal op 0000 afterwards -> err=1, result=0, flags remain 0.
